// File: rtl/cpu_bus_arbiter.sv
// Arbitrates the single memory bus between the fetch port and the data port.
// Round-robin or data-priority grant, with a watchdog that aborts stuck cycles.
module cpu_bus_arbiter #(
  parameter bit          PRIORITY_DATA = 1'b0,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_request,
  output logic        o_fetch_ready,
  input  logic [31:0] i_fetch_address,
  output logic [31:0] o_fetch_rdata,
  input  logic        i_data_request,
  input  logic        i_data_rw,
  output logic        o_data_ready,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_data_wdata,
  output logic [31:0] o_data_rdata,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic        o_error
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    DONE
  } state_t;

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT) - 32'd1;

  state_t      state;
  logic        last_data;
  logic [31:0] wdog;
  logic        grant_any;
  logic        grant_data;
  logic        wd_hit;
  logic        finish;

  // Data wins a conflict when prioritised or when fetch had the last grant.
  always_comb begin
    grant_any  = i_fetch_request | i_data_request;
    grant_data = i_data_request &
                 (~i_fetch_request | PRIORITY_DATA | ~last_data);
    wd_hit     = (TIMEOUT != 0) && (wdog == WD_LAST);
    finish     = i_bus_ready | wd_hit;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      last_data     <= 1'b1;
      wdog          <= '0;
      o_fetch_ready <= 1'b0;
      o_fetch_rdata <= '0;
      o_data_ready  <= 1'b0;
      o_data_rdata  <= '0;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata   <= '0;
      o_error       <= 1'b0;
    end else begin
      o_fetch_ready <= 1'b0;
      o_data_ready  <= 1'b0;
      o_error       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            o_bus_request <= 1'b1;
            last_data     <= grant_data;
            wdog          <= '0;
            state         <= grant_data ? DATA : FETCH;
            o_bus_address <= grant_data ? i_data_address
                                        : i_fetch_address;
            o_bus_rw      <= grant_data & i_data_rw;
            o_bus_wdata   <= grant_data ? i_data_wdata : '0;
          end
        end
        FETCH, DATA: begin
          if (finish) begin
            o_bus_request <= 1'b0;
            o_error       <= ~i_bus_ready;
            state         <= DONE;
            if (state == FETCH) begin
              o_fetch_ready <= 1'b1;
              o_fetch_rdata <= i_bus_ready ? i_bus_rdata : '0;
            end else begin
              o_data_ready <= 1'b1;
              // Writes leave the read-data register alone.
              if (!i_bus_ready)
                o_data_rdata <= '0;
              else if (!o_bus_rw)
                o_data_rdata <= i_bus_rdata;
            end
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Randomised bench for cpu_bus_arbiter: round-robin and data-priority
// instances, each checked every cycle against a transaction-level model.
module tb_cpu_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(int inst, string nm,
                              logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL i%0d.%s got=%h want=%h", inst, nm, act, exp);
    end
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int K  = k;
    localparam bit PD = (k == 1);

    logic        rst;
    logic        freq, fready;
    logic [31:0] faddr, frdata;
    logic        dreq, drw, dready;
    logic [31:0] daddr, dwdata, drdata;
    logic        breq, brw, bready, err;
    logic [31:0] baddr, bwdata, brdata;
    bit          fin = 1'b0;

    cpu_bus_arbiter #(.PRIORITY_DATA(PD), .TIMEOUT(8)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_fetch_request(freq), .o_fetch_ready(fready),
      .i_fetch_address(faddr), .o_fetch_rdata(frdata),
      .i_data_request(dreq), .i_data_rw(drw),
      .o_data_ready(dready), .i_data_address(daddr),
      .i_data_wdata(dwdata), .o_data_rdata(drdata),
      .o_bus_request(breq), .o_bus_rw(brw),
      .i_bus_ready(bready), .o_bus_address(baddr),
      .o_bus_wdata(bwdata), .i_bus_rdata(brdata),
      .o_error(err)
    );

    // Transaction-level reference: owner 0 = none, 1 = fetch, 2 = data.
    int          m_own, m_age, m_last;
    bit          m_done;
    logic        e_breq, e_rw, e_fr, e_dr, e_err;
    logic [31:0] e_addr, e_wdata, e_frd, e_drd;

    task automatic m_reset();
      m_own = 0; m_age = 0; m_last = 2; m_done = 0;
      e_breq = 0; e_rw = 0; e_fr = 0; e_dr = 0; e_err = 0;
      e_addr = 0; e_wdata = 0; e_frd = 0; e_drd = 0;
    endtask

    initial begin
      int  gnt;
      bit  tmo;
      m_reset();
      forever begin
        @(posedge clk);
        if (rst) begin
          m_reset();
        end else begin
          e_fr = 0; e_dr = 0; e_err = 0;
          if (m_done) begin
            m_done = 0;
          end else if (m_own == 0) begin
            gnt = 0;
            if (freq && dreq) gnt = PD ? 2 : (m_last == 2 ? 1 : 2);
            else if (freq) gnt = 1;
            else if (dreq) gnt = 2;
            if (gnt != 0) begin
              m_own = gnt; m_last = gnt; m_age = 0;
              e_breq = 1;
              e_addr = (gnt == 1) ? faddr : daddr;
              e_rw = (gnt == 2) && drw;
              e_wdata = dwdata;
            end
          end else if (bready || m_age == 7) begin
            tmo = !bready;
            e_breq = 0;
            e_err = tmo;
            if (m_own == 1) begin
              e_fr = 1;
              e_frd = tmo ? 32'h0 : brdata;
            end else begin
              e_dr = 1;
              if (tmo) e_drd = 0;
              else if (!e_rw) e_drd = brdata;
            end
            m_own = 0; m_done = 1;
          end else begin
            m_age++;
          end
        end
        @(negedge clk);
        if (rst) begin
          m_reset();
          chk(K, "rst_breq", {31'b0, breq}, 0);
          chk(K, "rst_rdy", {30'b0, fready, dready}, 0);
          chk(K, "rst_err", {31'b0, err}, 0);
        end else begin
          chk(K, "bus_req", {31'b0, breq}, {31'b0, e_breq});
          chk(K, "f_ready", {31'b0, fready}, {31'b0, e_fr});
          chk(K, "d_ready", {31'b0, dready}, {31'b0, e_dr});
          chk(K, "error", {31'b0, err}, {31'b0, e_err});
          if (e_breq) begin
            chk(K, "bus_addr", baddr, e_addr);
            chk(K, "bus_rw", {31'b0, brw}, {31'b0, e_rw});
            if (e_rw) chk(K, "bus_wdata", bwdata, e_wdata);
          end
          if (e_fr) chk(K, "f_rdata", frdata, e_frd);
          if (e_dr) chk(K, "d_rdata", drdata, e_drd);
        end
      end
    end

    // Requesters and bus responder, updated 1 time unit after each edge.
    int cyc = 0, lat = 2, cnt = 0, ovr = -1;
    bit quiet = 0;

    task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (fready) freq = 0;
      else if (!quiet && cyc > 8) begin
        if (!freq && $urandom_range(0, 3) == 0) begin
          freq = 1; faddr = $urandom;
        end else if (freq && $urandom_range(0, 15) == 0) faddr = $urandom;
        else if (freq && $urandom_range(0, 31) == 0) freq = 0;
      end
      if (dready) dreq = 0;
      else if (!quiet && cyc > 8) begin
        if (!dreq && $urandom_range(0, 3) == 0) begin
          dreq = 1; daddr = $urandom; dwdata = $urandom;
          drw = 1'($urandom_range(0, 1));
        end else if (dreq && $urandom_range(0, 15) == 0) dwdata = $urandom;
        else if (dreq && $urandom_range(0, 31) == 0) dreq = 0;
      end
      if (breq) begin
        bready = (cnt == lat);
        brdata = (cyc < 8) ? 32'hDEADBEEF : $urandom;
        cnt++;
      end else begin
        cnt = 0;
        lat = (ovr >= 0) ? ovr : (cyc > 8 ? int'($urandom_range(0, 9)) : 2);
        bready = (cyc > 8) && ($urandom_range(0, 7) == 0);
        brdata = $urandom;
      end
    endtask

    task automatic watch(int ov, logic [31:0] a, logic want_err);
      int  hi = 0;
      bit  seen = 0;
      ovr = ov;
      repeat (4) step();
      freq = 1; faddr = a;
      for (int i = 0; i < 40 && !seen; i++) begin
        step();
        if (breq) hi++;
        if (fready) begin
          seen = 1;
          chk(K, "wd_len", hi, 8);
          chk(K, "wd_err", {31'b0, err}, {31'b0, want_err});
          if (want_err) chk(K, "wd_rdata", frdata, 0);
        end
      end
      if (!seen) chk(K, "wd_done", 0, 1);
    endtask

    initial begin
      bit got;
      rst = 1; freq = 1; faddr = 32'h100;
      dreq = 1; drw = 1; daddr = 32'h2000; dwdata = 32'h12345678;
      bready = 0; brdata = 0;
      repeat (2) @(posedge clk);
      #2 rst = 0;
      for (int i = 1; i <= 9; i++) begin
        step();
        if (cyc == 1) begin
          chk(K, "first_addr", baddr, PD ? 32'h2000 : 32'h100);
          chk(K, "first_rw", {31'b0, brw}, {31'b0, PD});
          if (PD) chk(K, "first_wdata", bwdata, 32'h12345678);
        end
        if (cyc == 4) begin
          chk(K, "first_fr", {31'b0, fready}, {31'b0, !PD});
          chk(K, "first_dr", {31'b0, dready}, {31'b0, PD});
          if (PD) chk(K, "wr_rdata", drdata, 0);
          else chk(K, "fetch_rdata", frdata, 32'hDEADBEEF);
        end
        if (cyc == 6)
          chk(K, "second_addr", baddr, PD ? 32'h100 : 32'h2000);
      end
      repeat (3000) step();
      quiet = 1;
      freq = 0; dreq = 0;
      repeat (30) step();
      watch(99, 32'hC0, 1'b1);
      watch(7, 32'hC4, 1'b0);
      ovr = 99;
      repeat (4) step();
      dreq = 1; drw = 1; daddr = 32'h3000;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        step();
        got = breq;
      end
      if (!got) chk(K, "rst_txn", 0, 1);
      step();
      #2 rst = 1;
      #1;
      chk(K, "async_breq", {31'b0, breq}, 0);
      chk(K, "async_rdy", {30'b0, fready, dready}, 0);
      freq = 1; faddr = 32'h400;
      dreq = 1; daddr = 32'h500; drw = 0;
      @(posedge clk);
      #2 rst = 0;
      step();
      chk(K, "post_rst", baddr, PD ? 32'h500 : 32'h400);
      repeat (40) step();
      fin = 1;
    end
  end

  initial begin
    bit ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(posedge clk);
      ok = g[0].fin && g[1].fin;
    end
    if (!ok) chk(9, "bench_timeout", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares the CPU's single memory bus between the instruction prefetcher (fetch port, read-only) and the load/store unit (data port, read/write).
- Sits between the CPU core/prefetcher and the system bus.
- Serialises transactions and arbitrates round-robin, or with fixed data priority.
- A watchdog aborts transactions the bus never completes.

Parameters:
- PRIORITY_DATA, 0: 0 = round-robin on conflict; 1 = data always wins a conflict.
- TIMEOUT, 1024: bus cycles to wait for i_bus_ready before abort; 0 disables the watchdog.

Ports:
- i_clock  in  1  clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_fetch_request  in  1  fetch request, level, held until o_fetch_ready
- o_fetch_ready  out  1  one-cycle completion pulse to fetch port
- i_fetch_address  in  32  fetch address
- o_fetch_rdata  out  32  fetch read data, valid while o_fetch_ready=1
- i_data_request  in  1  data request, level, held until o_data_ready
- i_data_rw  in  1  0 = read, 1 = write
- o_data_ready  out  1  one-cycle completion pulse to data port
- i_data_address  in  32  data address
- i_data_wdata  in  32  write data
- o_data_rdata  out  32  data read data, valid while o_data_ready=1
- o_bus_request  out  1  bus request, level, held until i_bus_ready
- o_bus_rw  out  1  bus direction
- i_bus_ready  in  1  bus completion pulse
- o_bus_address  out  32  bus address
- o_bus_wdata  out  32  bus write data
- i_bus_rdata  in  32  bus read data, valid with i_bus_ready
- o_error  out  1  one-cycle pulse when a watchdog abort occurs

Behaviour:
- Reset (async, while i_reset=1):
  - all outputs 0; state IDLE; last_grant = DATA, so fetch wins the first round-robin conflict; watchdog counter 0.
  - Reset mid-transaction drops o_bus_request immediately (async); no ready pulse is issued.
- All outputs are registered.
- States: IDLE, FETCH, DATA, DONE.
- IDLE:
  - Sample requests. Only one pending -> grant it. Both pending -> PRIORITY_DATA=1: grant data; else grant the port that is not last_grant.
  - On grant, next cycle: o_bus_request=1; o_bus_address = the granted port's address; o_bus_rw = i_data_rw for data, 0 for fetch; o_bus_wdata = i_data_wdata for data.
  - Update last_grant; clear watchdog; go to FETCH or DATA.
- FETCH / DATA:
  - Bus outputs held stable; watchdog increments each cycle.
  - i_bus_ready=1 -> next cycle: o_bus_request=0; granted port's ready=1; its rdata = i_bus_rdata (rdata register updated on reads only; unchanged on writes); go to DONE.
  - Watchdog reaches TIMEOUT (TIMEOUT>0) without i_bus_ready -> next cycle: o_bus_request=0, o_error=1, granted ready=1, rdata=0; go to DONE.
  - If i_bus_ready and timeout occur in the same cycle, i_bus_ready wins and o_error stays 0.
- DONE:
  - Ready/error return to 0; exactly one cycle; no grant.
  - Requester drops its request in this cycle; back to IDLE.
  - A request still high in IDLE is treated as a new transaction.
- Latency:
  - Request sampled in IDLE at cycle N -> o_bus_request high at N+1.
  - i_bus_ready sampled at cycle M -> ready pulse at M+1.
  - Earliest next bus request at M+3.
  - Minimum total: 3 cycles plus bus latency.
- Request changes:
  - Address/data inputs are captured at grant; changes after grant are ignored.
  - A request dropped before ready is ignored; the transaction completes and a ready pulse is still issued.
- i_bus_ready outside FETCH/DATA is ignored.
- Only one of o_fetch_ready and o_data_ready is high in any cycle.

Test Plan:
- Fetch only:
  - Stimulus: fetch addr 0x00000100; bus returns rdata 0xDEADBEEF after 2 cycles.
  - Required: o_bus_address=0x100, o_bus_rw=0; o_fetch_ready one-cycle pulse with rdata 0xDEADBEEF; o_data_ready stays 0.
- Data write:
  - Stimulus: addr 0x2000, wdata 0x12345678, rw=1.
  - Required: bus outputs 0x2000 / 0x12345678 / rw=1 held until i_bus_ready; o_data_ready pulse; o_data_rdata unchanged.
- Simultaneous requests, PRIORITY_DATA=0:
  - Stimulus: both requests held from reset.
  - Required: grants alternate fetch, data, fetch, data; each ready exactly once per grant; bus request gap of 2 cycles between transactions.
- Simultaneous requests, PRIORITY_DATA=1:
  - Required: data granted first; fetch granted after data drops its request.
- Watchdog:
  - Stimulus: TIMEOUT=8; bus never ready.
  - Required: o_bus_request drops after 8 cycles; o_error and o_fetch_ready pulse together; rdata=0.
  - Then i_bus_ready and timeout in the same cycle -> normal completion with o_error=0.
- Reset mid-transaction:
  - Stimulus: assert i_reset while in DATA.
  - Required: o_bus_request=0 without waiting for a clock edge; no ready pulse; after release, the first fetch/data conflict grants fetch.
